// File: rtl/gcd_pkg.sv
// Shared types for the GCD unit: controller state encoding and the
// datapath operation select driven from the controller.
package gcd_pkg;

   // Controller states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Datapath operation requested by the controller for the coming edge
   typedef enum logic [1:0] {
      DP_HOLD = 2'd0,   // keep A, B, res
      DP_LOAD = 2'd1,   // A <= op_a, B <= op_b
      DP_STEP = 2'd2    // one subtract/swap/capture step
   } dp_sel_t;

endpackage

// File: rtl/gcd_dp.sv
// GCD datapath: operand registers A/B, compare, swap, subtract and the
// result register. The controller picks the operation through sel; b_zero
// tells it that the current step is the capture step.
module gcd_dp
   import gcd_pkg::*;
#(
   parameter int WL = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  dp_sel_t       sel,
   input  logic [WL-1:0] op_a,
   input  logic [WL-1:0] op_b,
   output logic          b_zero,
   output logic [WL-1:0] res
);

   logic [WL-1:0] a_q, a_d;
   logic [WL-1:0] b_q, b_d;
   logic [WL-1:0] res_q, res_d;

   assign b_zero = (b_q == '0);
   assign res    = res_q;

   // Next-value logic: load, or one step of subtractive Euclid (capture has priority)
   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      res_d = res_q;
      case (sel)
         DP_LOAD: begin
            a_d = op_a;
            b_d = op_b;
         end
         DP_STEP: begin
            if (b_q == '0) begin
               res_d = a_q;
            end else if (a_q < b_q) begin
               a_d = b_q;
               b_d = a_q;
            end else begin
               // A >= B here, so this never wraps
               a_d = a_q - b_q;
            end
         end
         default: ;
      endcase
   end

   // Datapath registers, cleared by reset at any time
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         res_q <= '0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         res_q <= res_d;
      end
   end

endmodule

// File: rtl/gcd_unit.sv
// GCD unit top: IDLE/CALC/DONE controller with valid/ready handshakes on
// both sides, driving the gcd_dp datapath.
// Optional feature macro: GCD_ITER_CNT_EN adds the iter_cnt output, a
// saturating count of CALC cycles spent on the current result.
module gcd_unit
   import gcd_pkg::*;
#(
   parameter int WL = 8,
   parameter int CW = WL + 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [WL-1:0] op_a,
   input  logic [WL-1:0] op_b,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [WL-1:0] res,
   output logic          busy
`ifdef GCD_ITER_CNT_EN
   ,
   output logic [CW-1:0] iter_cnt
`endif
);

   state_t  state_q, state_d;
   dp_sel_t dp_sel;
   logic    b_zero;
   logic    accept;

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == CALC);
   assign accept    = in_valid && (state_q == IDLE);

   // Next state and datapath select; inputs outside their state are ignored
   always_comb begin
      state_d = state_q;
      dp_sel  = DP_HOLD;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               dp_sel  = DP_LOAD;
               state_d = CALC;
            end
         end
         CALC: begin
            dp_sel = DP_STEP;
            if (b_zero) begin
               state_d = DONE;
            end
         end
         DONE: begin
            // Return to IDLE only; a new pair can be taken on the next cycle
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   gcd_dp #(
      .WL(WL)
   ) u_dp (
      .clk   (clk),
      .rst   (rst),
      .sel   (dp_sel),
      .op_a  (op_a),
      .op_b  (op_b),
      .b_zero(b_zero),
      .res   (res)
   );

`ifdef GCD_ITER_CNT_EN
   logic [CW-1:0] iter_cnt_q, iter_cnt_d;

   assign iter_cnt = iter_cnt_q;

   // Clear on accept, count every CALC cycle, stick at all-ones, hold otherwise
   always_comb begin
      iter_cnt_d = iter_cnt_q;
      if (accept) begin
         iter_cnt_d = '0;
      end else if ((state_q == CALC) && (iter_cnt_q != '1)) begin
         iter_cnt_d = iter_cnt_q + 1'b1;
      end
   end

   // Iteration counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         iter_cnt_q <= '0;
      end else begin
         iter_cnt_q <= iter_cnt_d;
      end
   end
`else
   // accept only feeds the iteration counter
   logic unused_accept;
   assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_gcd_unit.sv
// Self-checking bench for gcd_unit: directed table, reset/backpressure
// sequences and random operands against a behavioural GCD model.
// Build with +define+GCD_ITER_CNT_EN to also check iter_cnt.
module tb_gcd_unit;

   localparam int WL = 8;
   localparam int CW = WL + 2;
   localparam int MAX_WAIT = 2000;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [WL-1:0] op_a;
   logic [WL-1:0] op_b;
   logic          out_valid;
   logic          out_ready;
   logic [WL-1:0] res;
   logic          busy;
`ifdef GCD_ITER_CNT_EN
   logic [CW-1:0] iter_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   gcd_unit #(
      .WL(WL),
      .CW(CW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .op_a     (op_a),
      .op_b     (op_b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .res      (res),
      .busy     (busy)
`ifdef GCD_ITER_CNT_EN
      ,
      .iter_cnt (iter_cnt)
`endif
   );

   typedef struct {
      int unsigned a;
      int unsigned b;
      int          hold;
      int unsigned exp_res;
      int unsigned exp_n;
   } vec_t;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   // Reference GCD by the remainder form of Euclid
   function automatic int unsigned ref_gcd(input int unsigned a_in, input int unsigned b_in);
      int unsigned a = a_in;
      int unsigned b = b_in;
      int unsigned t;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   // Number of CALC cycles from the stated per-cycle rule (capture counts as one)
   function automatic int unsigned ref_steps(input int unsigned a_in, input int unsigned b_in);
      int unsigned a = a_in;
      int unsigned b = b_in;
      int unsigned t;
      int unsigned n = 0;
      while (1) begin
         n++;
         if (b == 0) break;
         if (a < b) begin
            t = a; a = b; b = t;
         end else begin
            a = a - b;
         end
      end
      return n;
   endfunction

   task automatic check_idle(input string tag);
      check({tag, " in_ready"},  32'(in_ready),  32'd1);
      check({tag, " out_valid"}, 32'(out_valid), 32'd0);
      check({tag, " busy"},      32'(busy),      32'd0);
   endtask

   // One full transaction; all driving and sampling at the falling edge
   task automatic run_op(input string tag, input int unsigned a, input int unsigned b,
                         input int hold, input int unsigned exp_res, input int unsigned exp_n);
      int          lat;
      int          w;
      logic [WL-1:0] res_before;
      bit          res_moved;
      bit          in_valid_toggled;

      w = 0;
      while (!in_ready && w < 10) begin
         @(negedge clk);
         w++;
      end
      op_a      = WL'(a);
      op_b      = WL'(b);
      in_valid  = 1'b1;
      out_ready = 1'b0;
      res_before = res;
      @(negedge clk);
      // First cycle after the accept edge
      check({tag, " busy after accept"}, 32'(busy), 32'd1);
      lat = 1;
      res_moved = 1'b0;
      in_valid_toggled = 1'b0;
      while (!out_valid && lat < MAX_WAIT) begin
         if (res !== res_before) res_moved = 1'b1;
         // Junk on the input side and out_ready while calculating
         in_valid  = 1'($urandom);
         in_valid_toggled |= in_valid;
         op_a      = WL'($urandom);
         op_b      = WL'($urandom);
         out_ready = 1'($urandom);
         @(negedge clk);
         lat++;
      end
      if (!out_valid) begin
         check({tag, " out_valid timeout"}, 32'(out_valid), 32'd1);
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         in_valid = 1'b0;
         out_ready = 1'b0;
         return;
      end
      check({tag, " res held during CALC"}, 32'(res_moved), 32'd0);
      check({tag, " latency"}, 32'(lat), 32'(exp_n + 1));
      check({tag, " res"}, 32'(res), 32'(exp_res));
`ifdef GCD_ITER_CNT_EN
      check({tag, " iter_cnt"}, 32'(iter_cnt), 32'(exp_n));
`endif
      // Backpressure: result must stay put
      for (int i = 0; i < hold; i++) begin
         out_ready = 1'b0;
         in_valid  = 1'b1;
         op_a      = WL'($urandom);
         op_b      = WL'($urandom);
         @(negedge clk);
         check({tag, " res stable"},       32'(res),       32'(exp_res));
         check({tag, " out_valid stable"}, 32'(out_valid), 32'd1);
         check({tag, " in_ready in DONE"}, 32'(in_ready),  32'd0);
      end
      // Handshake with in_valid high: the pair must not be taken this cycle
      out_ready = 1'b1;
      in_valid  = 1'b1;
      @(negedge clk);
      check_idle({tag, " after handshake"});
      check({tag, " res after handshake"}, 32'(res), 32'(exp_res));
      in_valid  = 1'b0;
      out_ready = 1'b0;
      $display("op %-10s a=%3d b=%3d res=%3d cycles=%0d hold=%0d junk_in_valid=%0d",
               tag, a, b, res, lat, hold, in_valid_toggled);
   endtask

   vec_t vecs[9];

   initial begin
      vecs[0] = '{a: 12,  b: 18,  hold: 0, exp_res: 6,   exp_n: 7};
      vecs[1] = '{a: 0,   b: 0,   hold: 0, exp_res: 0,   exp_n: 1};
      vecs[2] = '{a: 5,   b: 0,   hold: 1, exp_res: 5,   exp_n: 1};
      vecs[3] = '{a: 0,   b: 7,   hold: 0, exp_res: 7,   exp_n: 2};
      vecs[4] = '{a: 9,   b: 6,   hold: 5, exp_res: 3,   exp_n: 6};
      vecs[5] = '{a: 7,   b: 7,   hold: 2, exp_res: 7,   exp_n: 3};
      vecs[6] = '{a: 255, b: 255, hold: 0, exp_res: 255, exp_n: 3};
      vecs[7] = '{a: 255, b: 1,   hold: 0, exp_res: 1,   exp_n: 257};
      vecs[8] = '{a: 1,   b: 255, hold: 1, exp_res: 1,   exp_n: 258};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      op_a      = '0;
      op_b      = '0;
      repeat (2) @(negedge clk);
      check_idle("reset");
      check("reset res", 32'(res), 32'd0);
`ifdef GCD_ITER_CNT_EN
      check("reset iter_cnt", 32'(iter_cnt), 32'd0);
`endif
      rst = 1'b0;
      @(negedge clk);
      check_idle("post reset");

      // Directed table
      foreach (vecs[i]) begin
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].hold,
                vecs[i].exp_res, vecs[i].exp_n);
      end

      // Reset in the middle of a long calculation
      op_a     = 8'd255;
      op_b     = 8'd1;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      check("midcalc busy before reset", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check_idle("midcalc reset");
      check("midcalc reset res", 32'(res), 32'd0);
`ifdef GCD_ITER_CNT_EN
      check("midcalc reset iter_cnt", 32'(iter_cnt), 32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_idle("midcalc after release");
      run_op("after_rst", 8, 12, 0, 4, 7);

      // Random operands against the model
      for (int i = 0; i < 40; i++) begin
         int unsigned a;
         int unsigned b;
         a = $urandom_range(255, 0);
         b = $urandom_range(255, 0);
         if (i % 8 == 0) b = 0;
         if (i % 8 == 1) a = 0;
         run_op($sformatf("rnd%0d", i), a, b, $urandom_range(3, 0),
                ref_gcd(a, b), ref_steps(a, b));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
